// File: rtl/cg_pkg.sv
// Shared definitions for the matrix-vector collector path: FP32 field layout and collector states.
package cg_pkg;

    localparam int unsigned DW_FP32      = 32;
    localparam int unsigned EXP_MSB      = 30;
    localparam int unsigned EXP_LSB      = 23;
    localparam int unsigned EXP_W        = EXP_MSB - EXP_LSB + 1;
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_DONE
    } collector_state_e;

    // True for NaN or Inf: exponent field all ones.
    function automatic logic is_exp_all_ones(input logic [DW_FP32-1:0] word);
        return word[EXP_MSB:EXP_LSB] == EXP_ALL_ONES;
    endfunction

endpackage

// File: rtl/result_buffer_ram.sv
// Simple dual-port buffer: one write port, one registered read port with read enable.
module result_buffer_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value when re is low, so a stalled consumer sees stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/row_result_collector.sv
// Captures finished row dot-products into a buffer, then streams the full vector over valid/ready.
module row_result_collector
    import cg_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] acc_result,
    input  logic          acc_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [AW:0]   row_count,
    output logic          done,
    output logic          overflow_err,
    output logic          nan_flag
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [AW:0]   LAST_RD   = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);

    collector_state_e state, state_nxt;

    logic [AW-1:0] wr_ptr;
    logic [AW:0]   rd_ptr;   // next index to fetch; reaches DEPTH once the last word is fetched

    logic wr_en_c;
    logic last_wr_c;
    logic fetch_c;
    logic handshake_c;
    logic drain_end_c;
    logic stray_c;

    always_comb begin
        wr_en_c     = start && (state == ST_COLLECT) && acc_valid;
        last_wr_c   = wr_en_c && (wr_ptr == LAST_IDX);
        handshake_c = out_valid && out_ready;
        fetch_c     = start && (state == ST_DRAIN) && (!out_valid || out_ready)
                      && (rd_ptr != DEPTH_CNT);
        drain_end_c = start && (state == ST_DRAIN) && handshake_c && (rd_ptr == DEPTH_CNT);
        stray_c     = start && acc_valid && ((state == ST_DRAIN) || (state == ST_DONE));
    end

    result_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en_c),
        .waddr (wr_ptr),
        .wdata (acc_result),
        .re    (fetch_c),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_COLLECT;
                ST_COLLECT: if (last_wr_c) state_nxt = ST_DRAIN;
                ST_DRAIN:   if (drain_end_c) state_nxt = ST_DONE;
                ST_DONE:    state_nxt = ST_DONE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pointers, counters, stream control and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            row_count    <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            nan_flag     <= 1'b0;
        end else if (!start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            row_count <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                row_count    <= '0;
                overflow_err <= 1'b0;
                nan_flag     <= 1'b0;
            end

            if (wr_en_c) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (row_count != DEPTH_CNT) begin
                    row_count <= row_count + (AW + 1)'(1);
                end
                if (is_exp_all_ones(DW_FP32'(acc_result))) begin
                    nan_flag <= 1'b1;
                end
                if (last_wr_c) begin
                    rd_ptr <= '0;
                end
            end

            if (stray_c) begin
                overflow_err <= 1'b1;
            end

            if (fetch_c) begin
                out_valid <= 1'b1;
                out_last  <= (rd_ptr == LAST_RD);
                rd_ptr    <= rd_ptr + (AW + 1)'(1);
            end else if (drain_end_c) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_row_result_collector.sv
// Scoreboard bench for row_result_collector with DEPTH=4.
module tb_row_result_collector;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] acc_result;
    logic          acc_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [AW:0]   row_count;
    logic          done;
    logic          overflow_err;
    logic          nan_flag;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    row_result_collector #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .acc_result   (acc_result),
        .acc_valid    (acc_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .row_count    (row_count),
        .done         (done),
        .overflow_err (overflow_err),
        .nan_flag     (nan_flag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    task automatic capture(input logic [DW-1:0] w);
        acc_valid  = 1'b1;
        acc_result = w;
        exp_q.push_back(w);
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic capture_four(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        capture(w0);
        capture(w1);
        capture(w2);
        capture(w3);
    endtask

    // Drains the stream; stall_mode applies the ready pattern 1,0,0,1,0,0,...
    task automatic drain_check(input string name, input bit stall_mode);
        int got = 0;
        int cyc = 0;
        bit prev_stall = 1'b0;
        logic [DW-1:0] held_data = '0;
        logic held_last = 1'b0;
        logic rdy;
        logic [DW-1:0] exp_w;
        while (got < int'(DEPTH) && cyc < 200) begin
            tick();
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    errors++;
                    $display("FAIL %s_stall got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             name, out_valid, out_data, out_last, held_data, held_last);
                end
            end
            rdy = stall_mode ? ((cyc % 3) == 0) : 1'b1;
            out_ready = rdy;
            if (out_valid === 1'b1 && rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra got %h exp none", name, out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL %s_data%0d got %h exp %h", name, got, out_data, exp_w);
                    end
                end
                checks++;
                if (out_last !== (got == int'(DEPTH) - 1)) begin
                    errors++;
                    $display("FAIL %s_last%0d got %b exp %b", name, got, out_last,
                             (got == int'(DEPTH) - 1));
                end
                got++;
            end
            prev_stall = (out_valid === 1'b1) && !rdy;
            held_data  = out_data;
            held_last  = out_last;
            cyc++;
        end
        checks++;
        if (got != int'(DEPTH)) begin
            errors++;
            $display("FAIL %s_timeout got %0d words exp %0d", name, got, DEPTH);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || row_count !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL %s_end got v=%b done=%b rc=%0d exp v=0 done=1 rc=%0d",
                     name, out_valid, done, row_count, DEPTH);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover got %0d exp 0", name, exp_q.size());
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_hold got v=%b done=%b exp v=0 done=1", name, out_valid, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || row_count !== '0
            || overflow_err !== 1'b0 || nan_flag !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset got v=%b l=%b d=%b rc=%0d of=%b nan=%b data=%h exp all 0",
                     out_valid, out_last, done, row_count, overflow_err, nan_flag, out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        begin_run();
        checks++;
        if (row_count !== '0) begin
            errors++;
            $display("FAIL basic_rc0 got %0d exp 0", row_count);
        end
        // acc_valid in IDLE must be ignored
        start = 1'b0;
        tick();
        acc_valid = 1'b1;
        acc_result = 32'h12345678;
        start = 1'b1;
        tick();
        acc_valid = 1'b0;
        checks++;
        if (row_count !== '0 || overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore got rc=%0d of=%b exp rc=0 of=0", row_count, overflow_err);
        end
        capture_four(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        checks++;
        if (row_count !== 3'(DEPTH)) begin
            errors++;
            $display("FAIL basic_rc got %0d exp %0d", row_count, DEPTH);
        end
        drain_check("basic", 1'b0);
    endtask

    task automatic test_stall();
        begin_run();
        capture_four(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        drain_check("stall", 1'b1);
    endtask

    task automatic test_overflow();
        begin_run();
        capture_four(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        acc_valid  = 1'b1;
        acc_result = 32'hDEADBEEF;
        tick();
        acc_valid = 1'b0;
        checks++;
        if (overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag got %b exp 1", overflow_err);
        end
        drain_check("overflow", 1'b0);
        // start falling with acc_valid: start wins, so no new error on the next run
        begin_run();
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b exp 0", overflow_err);
        end
        capture_four(32'h1, 32'h2, 32'h3, 32'h4);
        drain_check("prio", 1'b0);
        start = 1'b0;
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        checks++;
        if (overflow_err !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_priority got of=%b done=%b exp of=0 done=0", overflow_err, done);
        end
    endtask

    task automatic test_nan();
        begin_run();
        capture(32'h3F800000);
        capture(32'h7FC00000);
        checks++;
        if (nan_flag !== 1'b1) begin
            errors++;
            $display("FAIL nan_set got %b exp 1", nan_flag);
        end
        capture(32'h40400000);
        capture(32'h40800000);
        drain_check("nan", 1'b0);
        checks++;
        if (nan_flag !== 1'b1) begin
            errors++;
            $display("FAIL nan_sticky got %b exp 1", nan_flag);
        end
        begin_run();
        checks++;
        if (nan_flag !== 1'b0) begin
            errors++;
            $display("FAIL nan_clear got %b exp 0", nan_flag);
        end
        capture(32'hFF800000);
        checks++;
        if (nan_flag !== 1'b1) begin
            errors++;
            $display("FAIL inf_set got %b exp 1", nan_flag);
        end
        start = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic test_restart();
        begin_run();
        capture(32'hAAAA0001);
        capture(32'hAAAA0002);
        checks++;
        if (row_count !== 3'd2) begin
            errors++;
            $display("FAIL restart_rc2 got %0d exp 2", row_count);
        end
        start = 1'b0;
        exp_q.delete();
        tick();
        checks++;
        if (row_count !== '0) begin
            errors++;
            $display("FAIL restart_rc0 got %0d exp 0", row_count);
        end
        start = 1'b1;
        tick();
        capture_four(32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000);
        drain_check("restart", 1'b1);
    endtask

    task automatic test_reset_mid_drain();
        begin_run();
        capture_four(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        acc_valid = 1'b1;
        tick();
        acc_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b0 || overflow_err !== 1'b0 || nan_flag !== 1'b0
            || out_last !== 1'b0 || row_count !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b d=%b of=%b nan=%b l=%b rc=%0d exp all 0",
                     out_valid, done, overflow_err, nan_flag, out_last, row_count);
        end
        exp_q.delete();
        out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || row_count !== '0) begin
            errors++;
            $display("FAIL reset_release got v=%b rc=%0d exp v=0 rc=0", out_valid, row_count);
        end
        capture_four(32'h42000000, 32'h42100000, 32'h42200000, 32'h42300000);
        drain_check("post_reset", 1'b0);
    endtask

    initial begin
        clk        = 1'b0;
        rst_n      = 1'b1;
        start      = 1'b0;
        acc_result = '0;
        acc_valid  = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_nan();
        test_restart();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
